// File: rtl/chacha_block_gen.sv
// chacha_block_gen: ChaCha keystream block generator.
// Takes a job (key, nonce, first counter, block count), runs ROUNDS rounds at
// QR_PER_CYCLE quarter-rounds per clock, adds the initial state and presents
// one 512-bit block per counter value on a back-pressured output.
//
// state   | meaning
// S_IDLE  | waiting for a job; start_ready_o high
// S_ROUND | one quarter-round group per cycle on the working state
// S_ADD   | working + init state captured into the output register
// S_OUT   | block presented; held until the consumer accepts it
// S_FIN   | one-cycle done_o pulse, then back to S_IDLE
module chacha_block_gen #(
    parameter int ROUNDS       = 20,
    parameter int QR_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid_i,
    output logic         start_ready_o,
    input  logic [255:0] key_i,
    input  logic [95:0]  nonce_i,
    input  logic [31:0]  ctr_i,
    input  logic [15:0]  nblocks_i,
    output logic [511:0] blk_data_o,
    output logic [31:0]  blk_ctr_o,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         ctr_wrap_o
);

    localparam int R_CYC  = ROUNDS * 4 / QR_PER_CYCLE;
    localparam int GROUPS = 4 / QR_PER_CYCLE;
    localparam int CW     = $clog2(R_CYC);
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUND,
        S_ADD,
        S_OUT,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   key_q, key_d;
    logic [95:0]    nonce_q, nonce_d;
    logic [31:0]    ctr_q, ctr_d;
    logic [15:0]    rem_q, rem_d;
    logic [511:0]   work_q, work_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [GW-1:0]  grp_q, grp_d;
    logic           diag_q, diag_d;
    logic [511:0]   data_q, data_d;
    logic [31:0]    bctr_q, bctr_d;
    logic           wrap_q, wrap_d;

    logic [511:0]   round_w;
    logic [511:0]   init_cur;
    logic [511:0]   sum_w;
    logic [31:0]    ctr_inc;
    logic [3:0]     ia, ib, ic, id;
    logic [1:0]     jj;
    logic [127:0]   qr_res;

    // Word 0 sits in the low 32 bits of the packed state.
    function automatic logic [511:0] init_state(input logic [255:0] k,
                                                input logic [95:0]  n,
                                                input logic [31:0]  c);
        return {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    endfunction

    // Returns {d, c, b, a} after one quarter-round.
    function automatic logic [127:0] quarter(input logic [31:0] a_in,
                                             input logic [31:0] b_in,
                                             input logic [31:0] c_in,
                                             input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    // Apply the selected QR group. QRs in one round touch disjoint words, so
    // applying the group members one after another is the same as in parallel.
    // Diagonal QR j uses words (j, 4+(j+1)%4, 8+(j+2)%4, 12+(j+3)%4).
    always_comb begin
        round_w = work_q;
        ia      = '0;
        ib      = '0;
        ic      = '0;
        id      = '0;
        jj      = '0;
        qr_res  = '0;
        for (int j = 0; j < 4; j++) begin
            if ((j / QR_PER_CYCLE) == int'(grp_q)) begin
                jj     = 2'(j);
                ia     = {2'b00, jj};
                ib     = {2'b01, jj + {1'b0, diag_q}};
                ic     = {2'b10, jj + {diag_q, 1'b0}};
                id     = {2'b11, jj + {diag_q, diag_q}};
                qr_res = quarter(round_w[{ia, 5'd0} +: 32], round_w[{ib, 5'd0} +: 32],
                                 round_w[{ic, 5'd0} +: 32], round_w[{id, 5'd0} +: 32]);
                round_w[{ia, 5'd0} +: 32] = qr_res[31:0];
                round_w[{ib, 5'd0} +: 32] = qr_res[63:32];
                round_w[{ic, 5'd0} +: 32] = qr_res[95:64];
                round_w[{id, 5'd0} +: 32] = qr_res[127:96];
            end
        end
    end

    // Final feed-forward: working state plus the init state of the current counter.
    always_comb begin
        init_cur = init_state(key_q, nonce_q, ctr_q);
        sum_w    = '0;
        for (int i = 0; i < 16; i++) begin
            sum_w[32*i +: 32] = work_q[32*i +: 32] + init_cur[32*i +: 32];
        end
    end

    assign ctr_inc = ctr_q + 32'd1;

    // Next-state and datapath updates for every state.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        work_d  = work_q;
        cyc_d   = cyc_q;
        grp_d   = grp_q;
        diag_d  = diag_q;
        data_d  = data_q;
        bctr_d  = bctr_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid_i) begin
                    key_d   = key_i;
                    nonce_d = nonce_i;
                    ctr_d   = ctr_i;
                    rem_d   = nblocks_i;
                    wrap_d  = 1'b0;
                    work_d  = init_state(key_i, nonce_i, ctr_i);
                    cyc_d   = CW'(R_CYC - 1);
                    grp_d   = '0;
                    diag_d  = 1'b0;
                    state_d = (nblocks_i == 16'd0) ? S_FIN : S_ROUND;
                end
            end
            S_ROUND: begin
                work_d = round_w;
                if (grp_q == GW'(GROUPS - 1)) begin
                    grp_d  = '0;
                    diag_d = ~diag_q;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
                if (cyc_q == '0) begin
                    state_d = S_ADD;
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            S_ADD: begin
                data_d  = sum_w;
                bctr_d  = ctr_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (blk_ready_i) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_FIN;
                    end else if (ctr_q == 32'hFFFF_FFFF) begin
                        // Never let the counter roll over to 0 inside a job.
                        wrap_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        ctr_d   = ctr_inc;
                        work_d  = init_state(key_q, nonce_q, ctr_inc);
                        cyc_d   = CW'(R_CYC - 1);
                        grp_d   = '0;
                        diag_d  = 1'b0;
                        state_d = S_ROUND;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset clears every visible output as well.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q   <= '0;
            nonce_q <= '0;
            ctr_q   <= '0;
            rem_q   <= '0;
            work_q  <= '0;
            cyc_q   <= '0;
            grp_q   <= '0;
            diag_q  <= 1'b0;
            data_q  <= '0;
            bctr_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ctr_q   <= ctr_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            cyc_q   <= cyc_d;
            grp_q   <= grp_d;
            diag_q  <= diag_d;
            data_q  <= data_d;
            bctr_q  <= bctr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign start_ready_o = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign blk_valid_o   = (state_q == S_OUT);
    assign done_o        = (state_q == S_FIN);
    assign blk_data_o    = data_q;
    assign blk_ctr_o     = bctr_q;
    assign ctr_wrap_o    = wrap_q;

endmodule
